// File: rtl/test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : test_monitor
// Purpose  : Watches a CPU core during a self-checking software test and
//            reports pass / fail / timeout. The monitor detects completion in
//            one of two ways:
//              MODE 0 : the PC reaches PASS_PC. The result is taken from a
//                       shadow copy of register RESULT_REG. A write to that
//                       register in the same cycle is forwarded.
//              MODE 1 : a non-zero store is made to TOHOST_ADDR. The result
//                       is the store data.
//            A result of 1 means pass. Any other value means fail, and
//            fail_code = result >> 1. If completion has not happened after
//            TIMEOUT cycles in RUN, the monitor reports a timeout.
//            PASS, FAIL and TIMEOUT are terminal states. Only rst leaves them.
// Ports    : clk, rst           - clock (rising edge), synchronous active-high reset
//            pc_valid, pc       - retired/fetched instruction address
//            rf_we/waddr/wdata  - register-file write port
//            st_valid/addr/data - data store port
//            done, done_pulse   - sticky finish flag and one-cycle entry strobe
//            pass, fail,        - sticky outcome flags (exactly one is high
//            timeout              while done is high)
//            fail_code          - failing test number
//            cycle_count        - cycles spent in RUN (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module test_monitor #(
    parameter int              XLEN        = 32,
    parameter int              MODE        = 0,
    parameter logic [XLEN-1:0] PASS_PC     = XLEN'(32'h44),
    parameter int              RESULT_REG  = 3,
    parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(32'h1000),
    parameter int              TIMEOUT     = 5000,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_valid,
    input  logic [XLEN-1:0]  pc,
    input  logic             rf_we,
    input  logic [4:0]       rf_waddr,
    input  logic [XLEN-1:0]  rf_wdata,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    output logic             done,
    output logic             done_pulse,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  fail_code,
    output logic [CNT_W-1:0] cycle_count
);

    // FSM encoding
    localparam logic [1:0] c_RUN     = 2'd0;
    localparam logic [1:0] c_PASS    = 2'd1;
    localparam logic [1:0] c_FAIL    = 2'd2;
    localparam logic [1:0] c_TIMEOUT = 2'd3;

    localparam logic [4:0]       c_RESULT_IDX = 5'(RESULT_REG);
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX    = '1;
    localparam logic [XLEN-1:0]  c_RES_PASS   = XLEN'(1);

    logic [1:0]       r_state;
    logic             r_done;
    logic             r_done_pulse;
    logic             r_pass;
    logic             r_fail;
    logic             r_timeout;
    logic [XLEN-1:0]  r_fail_code;
    logic [CNT_W-1:0] r_cycle;

    // Completion event and result value for this cycle, from the selected mode
    logic             w_evt;
    logic [XLEN-1:0]  w_result;

    // The configuration for the mode that is not selected is still referenced
    // here, so every elaboration uses every parameter.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{PASS_PC, TOHOST_ADDR, c_RESULT_IDX};

    generate
        if (MODE == 0) begin : g_mode0
            logic [XLEN-1:0] r_shadow;
            logic            w_wr_hit;
            logic            w_unused_st;

            // x0 is hard-wired zero, so a RESULT_REG of 0 never loads
            assign w_wr_hit = rf_we && (rf_waddr == c_RESULT_IDX) &&
                              (rf_waddr != 5'd0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_shadow <= '0;
                end else if (w_wr_hit) begin
                    r_shadow <= rf_wdata;
                end
            end

            assign w_evt    = pc_valid && (pc == PASS_PC);
            // A write in the same cycle as the completion PC carries the final value
            assign w_result = w_wr_hit ? rf_wdata : r_shadow;

            assign w_unused_st = ^{st_valid, st_addr, st_data};
        end else begin : g_mode1
            logic w_unused_rf;

            // Stores of zero to tohost are ignored, not reported as results
            assign w_evt    = st_valid && (st_addr == TOHOST_ADDR) &&
                              (st_data != '0);
            assign w_result = st_data;

            assign w_unused_rf = ^{pc_valid, pc, rf_we, rf_waddr, rf_wdata};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_RUN;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
            r_fail_code  <= '0;
            r_cycle      <= '0;
        end else begin
            r_done_pulse <= 1'b0;
            case (r_state)
                c_RUN: begin
                    // Completion is checked before the timeout, so completion
                    // wins when both happen in the same cycle.
                    // The counter keeps the value it had when RUN was left.
                    if (w_evt) begin
                        r_done       <= 1'b1;
                        r_done_pulse <= 1'b1;
                        if (w_result == c_RES_PASS) begin
                            r_state <= c_PASS;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state     <= c_FAIL;
                            r_fail      <= 1'b1;
                            r_fail_code <= w_result >> 1;
                        end
                    end else if (r_cycle == c_CNT_LAST) begin
                        r_state      <= c_TIMEOUT;
                        r_timeout    <= 1'b1;
                        r_done       <= 1'b1;
                        r_done_pulse <= 1'b1;
                    end else if (r_cycle != c_CNT_MAX) begin
                        r_cycle <= r_cycle + CNT_W'(1);
                    end
                end
                default: begin
                    // Terminal states hold every output until rst
                    r_state <= r_state;
                end
            endcase
        end
    end

    assign done        = r_done;
    assign done_pulse  = r_done_pulse;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign timeout     = r_timeout;
    assign fail_code   = r_fail_code;
    assign cycle_count = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_monitor
// Purpose  : Directed self-checking bench for test_monitor. One MODE 0
//            instance (TIMEOUT 20) and one MODE 1 instance share the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_monitor;

    logic        clk;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;

    logic        d0, dp0, p0, f0, t0;
    logic [31:0] fc0, cc0;
    logic        d1, dp1, p1, f1, t1;
    logic [31:0] fc1, cc1;

    int checks = 0;
    int errors = 0;

    test_monitor #(
        .XLEN(32), .MODE(0), .PASS_PC(32'h44), .RESULT_REG(3),
        .TOHOST_ADDR(32'h1000), .TIMEOUT(20), .CNT_W(32)
    ) u_m0 (
        .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .done(d0), .done_pulse(dp0), .pass(p0), .fail(f0), .timeout(t0),
        .fail_code(fc0), .cycle_count(cc0)
    );

    test_monitor #(
        .XLEN(32), .MODE(1), .PASS_PC(32'h44), .RESULT_REG(3),
        .TOHOST_ADDR(32'h1000), .TIMEOUT(5000), .CNT_W(32)
    ) u_m1 (
        .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .done(d1), .done_pulse(dp1), .pass(p1), .fail(f1), .timeout(t1),
        .fail_code(fc1), .cycle_count(cc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, and outputs are sampled there
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_valid = 1'b0; pc = '0;
        rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
        st_valid = 1'b0; st_addr = '0; st_data = '0;
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1; st_addr = a; st_data = d;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        // Reset state
        chk("rst_done", d0, 0);
        chk("rst_pulse", dp0, 0);
        chk("rst_pass", p0, 0);
        chk("rst_fail", f0, 0);
        chk("rst_timeout", t0, 0);
        chk("rst_fail_code", fc0, 0);
        chk("rst_cycle", cc0, 0);
        chk("rst_m1_done", d1, 0);
        rst = 1'b0;

        // MODE 0 pass, with a non-matching PC first
        pc_valid = 1'b1; pc = 32'h40;
        tick();
        chk("a_wrong_pc_done", d0, 0);
        chk("a_cycle1", cc0, 1);
        idle(); rf_write(5'd3, 32'd1);
        tick();
        idle(); pc_valid = 1'b1; pc = 32'h44;
        tick();
        chk("a_pass", p0, 1);
        chk("a_done", d0, 1);
        chk("a_pulse", dp0, 1);
        chk("a_fail", f0, 0);
        chk("a_timeout", t0, 0);
        chk("a_fail_code", fc0, 0);
        chk("a_cycle_frozen", cc0, 2);
        chk("a_m1_ignores_pc", d1, 0);
        idle();
        tick();
        chk("a_pulse_drop", dp0, 0);
        chk("a_pass_sticky", p0, 1);
        chk("a_done_sticky", d0, 1);

        // rst after pass, then the pass sequence is detected again
        rst = 1'b1;
        tick();
        chk("f_rst_pass", p0, 0);
        chk("f_rst_done", d0, 0);
        chk("f_rst_cycle", cc0, 0);
        rst = 1'b0;
        tick();
        chk("f_restart_cycle", cc0, 1);
        chk("f_restart_done", d0, 0);
        rf_write(5'd3, 32'd1); pc_valid = 1'b1; pc = 32'h44;
        tick();
        chk("f_repass", p0, 1);
        chk("f_repulse", dp0, 1);

        // MODE 0 fail; a write to another register is not captured
        reset_dut();
        rf_write(5'd3, 32'h0B);
        tick();
        rf_write(5'd4, 32'd1);
        tick();
        idle(); pc_valid = 1'b1; pc = 32'h44;
        tick();
        chk("b_fail", f0, 1);
        chk("b_pass", p0, 0);
        chk("b_fail_code", fc0, 5);
        chk("b_pulse", dp0, 1);
        idle(); rf_write(5'd3, 32'd1);
        tick();
        idle(); pc_valid = 1'b1; pc = 32'h44;
        tick();
        chk("b_fail_hold", f0, 1);
        chk("b_pass_hold", p0, 0);
        chk("b_code_hold", fc0, 5);
        chk("b_pulse_hold", dp0, 0);
        chk("b_done_hold", d0, 1);

        // Same-cycle write forwarding
        reset_dut();
        rf_write(5'd3, 32'h07);
        tick();
        rf_write(5'd3, 32'd1); pc_valid = 1'b1; pc = 32'h44;
        tick();
        chk("c_fwd_pass", p0, 1);
        chk("c_fwd_fail", f0, 0);
        chk("c_fwd_cycle", cc0, 1);

        // Timeout after 20 RUN cycles
        reset_dut();
        repeat (19) tick();
        chk("d_pre_cycle", cc0, 19);
        chk("d_pre_timeout", t0, 0);
        chk("d_pre_done", d0, 0);
        tick();
        chk("d_timeout", t0, 1);
        chk("d_done", d0, 1);
        chk("d_pulse", dp0, 1);
        chk("d_pass", p0, 0);
        chk("d_fail", f0, 0);
        chk("d_cycle", cc0, 19);
        repeat (3) tick();
        chk("d_cycle_frozen", cc0, 19);
        chk("d_pulse_drop", dp0, 0);
        chk("d_timeout_sticky", t0, 1);

        // Completion on the last budget cycle wins over the timeout
        reset_dut();
        rf_write(5'd3, 32'd1);
        tick();
        idle();
        repeat (18) tick();
        chk("e_last_cycle", cc0, 19);
        pc_valid = 1'b1; pc = 32'h44;
        tick();
        chk("e_race_pass", p0, 1);
        chk("e_race_timeout", t0, 0);
        chk("e_race_cycle", cc0, 19);

        // MODE 1 tohost stores
        reset_dut();
        store(32'h1000, 32'd0);
        tick();
        chk("g_zero_store", d1, 0);
        store(32'h1004, 32'd1);
        tick();
        chk("g_wrong_addr", d1, 0);
        store(32'h1000, 32'h7);
        tick();
        chk("g_fail", f1, 1);
        chk("g_pass", p1, 0);
        chk("g_fail_code", fc1, 3);
        chk("g_pulse", dp1, 1);
        chk("g_m0_ignores_st", d0, 0);
        store(32'h1000, 32'd1);
        tick();
        chk("g_fail_hold", f1, 1);
        chk("g_pass_hold", p1, 0);
        chk("g_code_hold", fc1, 3);
        chk("g_pulse_drop", dp1, 0);

        reset_dut();
        store(32'h1000, 32'd1);
        tick();
        chk("h_pass", p1, 1);
        chk("h_done", d1, 1);
        chk("h_cycle", cc1, 0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter MODE, default 0: 0 = PC-match + result register; 1 = tohost store.
REQ-003 SHALL have parameter PASS_PC, default 32'h44, completion PC (MODE 0).
REQ-004 SHALL have parameter RESULT_REG, default 3, register index holding the result (MODE 0).
REQ-005 SHALL have parameter TOHOST_ADDR, default 32'h1000, completion store address (MODE 1).
REQ-006 SHALL have parameter TIMEOUT, default 5000, cycle budget before timeout.
REQ-007 SHALL have parameter CNT_W, default 32, cycle counter width.
REQ-008 SHALL have ports: clk  in  1  clock; one clock, all logic on rising edge.
REQ-009 rst  in  1  reset; synchronous, active-high.
REQ-010 pc_valid  in  1  pc qualifies a retired/fetched instruction this cycle.
REQ-011 pc  in  XLEN  program counter.
REQ-012 rf_we  in  1  register-file write enable.
REQ-013 rf_waddr  in  5  register-file write index.
REQ-014 rf_wdata  in  XLEN  register-file write data.
REQ-015 st_valid  in  1  data store issued this cycle.
REQ-016 st_addr  in  XLEN  store address.
REQ-017 st_data  in  XLEN  store data.
REQ-018 done  out  1  test finished (pass, fail or timeout), sticky.
REQ-019 done_pulse  out  1  single-cycle strobe on entry to a terminal state.
REQ-020 pass  out  1  test passed, sticky.
REQ-021 fail  out  1  test failed, sticky.
REQ-022 timeout  out  1  budget exhausted, sticky.
REQ-023 fail_code  out  XLEN  failing test number (result value >> 1).
REQ-024 cycle_count  out  CNT_W  cycles spent in RUN.

Function
REQ-025 SHALL implement FSM states RUN, PASS, FAIL, TIMEOUT; PASS/FAIL/TIMEOUT terminal, left only by rst.
REQ-026 SHALL keep a shadow of register RESULT_REG, loaded when rf_we=1 and rf_waddr=RESULT_REG; writes with rf_waddr=0 ignored.
REQ-027 MODE 0: in RUN, pc_valid=1 and pc=PASS_PC is the completion event; result = shadow, with a same-cycle RESULT_REG write forwarded (new value used).
REQ-028 MODE 1: in RUN, st_valid=1, st_addr=TOHOST_ADDR, st_data!=0 is the completion event; result = st_data; stores of 0 ignored.
REQ-029 On completion: result=1 -> PASS; otherwise -> FAIL with fail_code = result >> 1 (logical).
REQ-030 cycle_count SHALL increment by 1 each cycle in RUN, saturate at all-ones, freeze in terminal states.
REQ-031 In RUN, when cycle_count = TIMEOUT-1 and no completion event that cycle -> TIMEOUT.
REQ-032 Completion event and timeout in the same cycle: completion wins.
REQ-033 All outputs SHALL be registered; status outputs assert the cycle after the qualifying event edge (latency 1).
REQ-034 done = pass|fail|timeout; exactly one of pass/fail/timeout high when done=1.
REQ-035 done_pulse SHALL be high for exactly one cycle, coincident with done rising.
REQ-036 Events after entering a terminal state SHALL not change any output.
REQ-037 Inputs unused by the selected MODE SHALL have no effect.

Reset
REQ-038 rst=1 at a rising edge SHALL force state RUN, shadow 0, cycle_count 0, fail_code 0, done/done_pulse/pass/fail/timeout 0.
REQ-039 rst asserted mid-test or in a terminal state SHALL restart monitoring from cycle 0 on the first cycle after rst deasserts.

Verification
REQ-040 MODE0: write x3=1, then pc_valid with pc=0x44 -> next cycle pass=1, done=1, done_pulse=1 one cycle, fail_code=0.
REQ-041 MODE0: write x3=0x0B, then pc=0x44 -> fail=1, fail_code=5; later x3=1 and pc=0x44 -> outputs unchanged.
REQ-042 MODE0: x3 write of 1 in the same cycle as pc=0x44 with prior shadow 0x07 -> pass=1 (forwarding).
REQ-043 TIMEOUT=20, no completion -> timeout=1 after 20 RUN cycles, cycle_count=19 frozen; completion on cycle 19 instead -> pass/fail, timeout=0.
REQ-044 MODE1: store 0 to 0x1000 -> no change; store 1 to 0x1004 -> no change; store 0x7 to 0x1000 -> fail=1, fail_code=3.
REQ-045 rst pulsed after pass=1 -> all outputs 0, cycle_count restarts at 0, subsequent pass sequence detected again.
